// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART 8N1 program-image receiver that writes 32-bit words into imem.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_uart_loader #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int WORDS  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       uart_rx,
  input  logic                       load_en,
  output logic                       imem_we,
  output logic [31:0]                imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       frame_err,
  output logic                       chk_err,
  output logic [$clog2(WORDS+1)-1:0] word_count
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam int WW  = $clog2(WORDS + 1);
  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            sample, byte_ok, byte_bad;
  logic            load_en_d, arm, commit, chk_phase;
  logic [WW-1:0]   word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     word_buf;

  // Sync flops idle high so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sample     = 1'b0;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
    case (state)
      S_IDLE:  if (rx_prev && !rx_sync) state_next = S_START;
      S_START: if (clk_cnt == HALF_LAST) state_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA: begin
        if (clk_cnt == CPB_LAST) begin
          sample = 1'b1;
          if (bit_cnt == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt == CPB_LAST) begin
          byte_ok    = rx_sync;
          byte_bad   = !rx_sync;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == S_IDLE || state_next != state || sample) clk_cnt <= '0;
      else                                                  clk_cnt <= clk_cnt + 1'b1;
      if (state != S_DATA) bit_cnt <= '0;
      else if (sample)     bit_cnt <= bit_cnt + 1'b1;
      if (sample) shreg <= {rx_sync, shreg[7:1]};
    end
  end

  assign arm    = load_en && !load_en_d && !busy;
  assign commit = busy && load_en && byte_ok && !chk_phase && (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      load_en_d  <= 1'b0;
    end else begin
      load_en_d <= load_en;
      imem_we   <= 1'b0;
      // Abort outranks everything, including a word completing this cycle.
      if (busy && !load_en) begin
        busy     <= 1'b0;
        byte_idx <= '0;
      end else if (arm) begin
        word_idx  <= '0;
        byte_idx  <= '0;
        done      <= 1'b0;
        frame_err <= 1'b0;
        busy      <= 1'b1;
      end else if (busy && byte_bad) begin
        frame_err <= 1'b1;
        byte_idx  <= '0;
      end else if (busy && byte_ok && chk_phase) begin
        done <= 1'b1;
        busy <= 1'b0;
      end else if (commit) begin
        imem_we    <= 1'b1;
        imem_addr  <= 32'(word_idx) << 2;
        imem_wdata <= {shreg, word_buf};
        word_idx   <= word_idx + 1'b1;
        byte_idx   <= '0;
`ifndef LOADER_CHECKSUM_EN
        if (word_idx == WW'(WORDS - 1)) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
`endif
      end else if (busy && byte_ok) begin
        word_buf[{byte_idx, 3'b000} +: 8] <= shreg;
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  assign word_count = word_idx;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       chk_q;

  assign chk_phase = (word_idx == WW'(WORDS));

  // Summed per committed word so bytes of dropped partial words never count.
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      sum   <= '0;
      chk_q <= 1'b0;
    end else if (commit) begin
      sum <= sum + word_buf[7:0] + word_buf[15:8] + word_buf[23:16] + shreg;
    end else if (busy && load_en && byte_ok && chk_phase) begin
      chk_q <= (sum != shreg);
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_phase = 1'b0;
  assign chk_err   = 1'b0;
`endif

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - directed self-checking bench for imem_uart_loader.
// Covers the LOADER_CHECKSUM_EN build too when that macro is defined.
module tb_imem_uart_loader;
  localparam int CLK_HZ = 3_686_400;
  localparam int BAUD   = 115200;
  localparam int WORDS  = 2;
  localparam int CPB    = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        rst, uart_rx, load_en;
  logic        imem_we, busy, done, frame_err, chk_err;
  logic [31:0] imem_addr, imem_wdata;
  logic [1:0]  word_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .load_en(load_en),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .frame_err(frame_err), .chk_err(chk_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic arm();
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    load_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if ({imem_we, busy, done, frame_err, chk_err} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", {imem_we, busy, done, frame_err, chk_err}); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    n_tests++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
    n_tests++; if (word_count !== 2'd0) begin n_fail++; $display("FAIL reset_word_count got %0d want 0", word_count); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    int base;
    arm();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arm_busy got %b want 1", busy); end
    base = wr_addr.size();
    send_byte(8'h93); send_byte(8'h03); send_byte(8'h40); send_byte(8'h01);
    n_tests++; if (wr_addr.size() !== base + 1) begin n_fail++; $display("FAIL single_count got %0d want %0d", wr_addr.size(), base + 1); end
    else begin
      n_tests++; if (wr_addr[base] !== 32'h0) begin n_fail++; $display("FAIL single_addr got %h want 0", wr_addr[base]); end
      n_tests++; if (wr_data[base] !== 32'h01400393) begin n_fail++; $display("FAIL single_data got %h want 01400393", wr_data[base]); end
    end
    n_tests++; if (word_count !== 2'd1) begin n_fail++; $display("FAIL single_word_count got %0d want 1", word_count); end
    n_tests++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL single_busy_done got %b want 10", {busy, done}); end
  endtask

  task automatic test_two_words(input logic [7:0] chk_byte, input logic chk_exp);
    int base;
    arm();
    base = wr_addr.size();
    for (int i = 0; i < 8; i++) send_byte(8'(i));
`ifdef LOADER_CHECKSUM_EN
    n_tests++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL chk_wait_busy_done got %b want 10", {busy, done}); end
    send_byte(chk_byte);
`endif
    n_tests++; if (wr_addr.size() !== base + 2) begin n_fail++; $display("FAIL two_count got %0d want %0d", wr_addr.size(), base + 2); end
    else begin
      n_tests++; if ({wr_addr[base], wr_data[base]} !== {32'h0, 32'h03020100}) begin n_fail++; $display("FAIL two_w0 got %h@%h want 03020100@0", wr_data[base], wr_addr[base]); end
      n_tests++; if ({wr_addr[base+1], wr_data[base+1]} !== {32'h4, 32'h07060504}) begin n_fail++; $display("FAIL two_w1 got %h@%h want 07060504@4", wr_data[base+1], wr_addr[base+1]); end
    end
    n_tests++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL two_busy_done got %b want 01", {busy, done}); end
    n_tests++; if (word_count !== 2'd2) begin n_fail++; $display("FAIL two_word_count got %0d want 2", word_count); end
    n_tests++; if (chk_err !== chk_exp) begin n_fail++; $display("FAIL two_chk_err got %b want %b", chk_err, chk_exp); end
    send_byte(8'h99);
    n_tests++; if (wr_addr.size() !== base + 2 || done !== 1'b1) begin n_fail++; $display("FAIL after_done got %0d writes done=%b want %0d done=1", wr_addr.size(), done, base + 2); end
  endtask

  task automatic test_frame_err();
    int base;
    arm();
    base = wr_addr.size();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h55, 1'b0);
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_set got %b want 1", frame_err); end
    n_tests++; if (wr_addr.size() !== base) begin n_fail++; $display("FAIL frame_no_write got %0d want %0d", wr_addr.size(), base); end
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    n_tests++; if (wr_addr.size() !== base + 1) begin n_fail++; $display("FAIL frame_resync_count got %0d want %0d", wr_addr.size(), base + 1); end
    else begin
      n_tests++; if ({wr_addr[base], wr_data[base]} !== {32'h0, 32'hDDCCBBAA}) begin n_fail++; $display("FAIL frame_resync_word got %h@%h want DDCCBBAA@0", wr_data[base], wr_addr[base]); end
    end
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_sticky got %b want 1", frame_err); end
  endtask

  task automatic test_glitch();
    int base;
    arm();
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL arm_clears_frame_err got %b want 0", frame_err); end
    base = wr_addr.size();
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_tests++; if ({frame_err, word_count} !== 3'b000 || wr_addr.size() !== base) begin n_fail++; $display("FAIL glitch_quiet got fe=%b wc=%0d writes=%0d want 0 0 %0d", frame_err, word_count, wr_addr.size(), base); end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    n_tests++; if (wr_addr.size() !== base + 1) begin n_fail++; $display("FAIL glitch_count got %0d want %0d", wr_addr.size(), base + 1); end
    else begin
      n_tests++; if ({wr_addr[base], wr_data[base]} !== {32'h0, 32'h78563412}) begin n_fail++; $display("FAIL glitch_word got %h@%h want 78563412@0", wr_data[base], wr_addr[base]); end
    end
  endtask

  task automatic test_abort();
    int base;
    arm();
    base = wr_addr.size();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    load_en = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (4 * CPB) @(negedge clk);
    n_tests++; if (wr_addr.size() !== base || word_count !== 2'd0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_state got writes=%0d wc=%0d done=%b want %0d 0 0", wr_addr.size(), word_count, done, base); end
    arm();
    send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    n_tests++; if (wr_addr.size() !== base + 1) begin n_fail++; $display("FAIL rearm_count got %0d want %0d", wr_addr.size(), base + 1); end
    else begin
      n_tests++; if ({wr_addr[base], wr_data[base]} !== {32'h0, 32'hC3C2C1C0}) begin n_fail++; $display("FAIL rearm_word got %h@%h want C3C2C1C0@0", wr_data[base], wr_addr[base]); end
    end
  endtask

  task automatic test_rst_mid_word();
    int base;
    arm();
    base = wr_addr.size();
    send_byte(8'hE0); send_byte(8'hE1);
    uart_rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if ({busy, imem_we, word_count, imem_addr, imem_wdata} !== 68'h0) begin n_fail++; $display("FAIL mid_rst_state got busy=%b we=%b wc=%0d addr=%h wdata=%h want all 0", busy, imem_we, word_count, imem_addr, imem_wdata); end
    load_en = 1'b0; uart_rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    arm();
    send_byte(8'hF0); send_byte(8'hF1); send_byte(8'hF2); send_byte(8'hF3);
    n_tests++; if (wr_addr.size() !== base + 1) begin n_fail++; $display("FAIL mid_rst_count got %0d want %0d", wr_addr.size(), base + 1); end
    else begin
      n_tests++; if ({wr_addr[base], wr_data[base]} !== {32'h0, 32'hF3F2F1F0}) begin n_fail++; $display("FAIL mid_rst_word got %h@%h want F3F2F1F0@0", wr_data[base], wr_addr[base]); end
    end
  endtask

  task automatic test_idle_discard();
    int base;
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    base = wr_addr.size();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03, 1'b0);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    n_tests++; if (wr_addr.size() !== base || {busy, done, frame_err} !== 3'b000 || word_count !== 2'd1) begin n_fail++; $display("FAIL idle_discard got writes=%0d bdf=%b wc=%0d want %0d 000 1", wr_addr.size(), {busy, done, frame_err}, word_count, base); end
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; uart_rx = 1'b1;
    test_reset();
    test_single_word();
    test_two_words(8'h1C, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    test_two_words(8'h1D, 1'b1);
`endif
    test_frame_err();
    test_glitch();
    test_abort();
    test_rst_mid_word();
    test_idle_discard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
